// File: rtl/gate_response_checker_if.sv
// rtl/gate_response_checker_if.sv - control and vector bundle between a gate stimulus bench and its response checker
interface gate_response_checker_if;
  logic start;
  logic end_test;
  logic in_valid;
  logic a;
  logic b;
  logic c_obs;

  modport master (output start, end_test, in_valid, a, b, c_obs);
  modport slave  (input  start, end_test, in_valid, a, b, c_obs);
endinterface

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - latency-aware compare of a 2-input gate DUT output with counters, coverage and first-fail capture
module gate_response_checker #(
  parameter int GATE_OP = 3,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_response_checker_if.slave vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   err_pulse,
  output logic                   err_sticky,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [CNT_W-1:0]       check_cnt,
  output logic [3:0]             coverage,
  output logic [1:0]             first_err_vec
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t       CNT_MAX   = '1;
  localparam logic [2:0] OP        = 3'(GATE_OP);
  // A zero-latency DUT still spends one cycle in DRAIN so the report timing is uniform.
  localparam logic [1:0] DRAIN_LEN = (DUT_LAT == 0) ? 2'd1 : 2'(DUT_LAT);

  state_t     state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       enter_done;
  logic       cmp_valid, cmp_a, cmp_b, cmp_exp;
  logic       mism;
  cnt_t       check_nx, mismatch_nx;
  logic [3:0] cov_nx;

  function automatic logic gate_fn(input logic x, input logic y);
    case (OP)
      3'd0:    gate_fn = x & y;
      3'd1:    gate_fn = x | y;
      3'd2:    gate_fn = ~(x & y);
      3'd4:    gate_fn = x ^ y;
      3'd5:    gate_fn = ~(x ^ y);
      default: gate_fn = ~(x | y);
    endcase
  endfunction

  generate
    if (DUT_LAT == 0) begin : g_direct
      assign cmp_valid = (state_q == RUN) && vec.in_valid;
      assign cmp_a     = vec.a;
      assign cmp_b     = vec.b;
      assign cmp_exp   = gate_fn(vec.a, vec.b);
    end else begin : g_pipe
      typedef logic [DUT_LAT-1:0] pipe_t;
      pipe_t pv, pa, pb, pe;
      logic  load;

      assign load = (state_q == RUN) && vec.in_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
          pa <= '0;
          pb <= '0;
          pe <= '0;
        end else if (vec.start) begin
          pv <= '0;
        end else begin
          pv <= (pv << 1) | pipe_t'(load);
          pa <= (pa << 1) | pipe_t'(vec.a);
          pb <= (pb << 1) | pipe_t'(vec.b);
          pe <= (pe << 1) | pipe_t'(gate_fn(vec.a, vec.b));
        end
      end

      assign cmp_valid = pv[DUT_LAT-1];
      assign cmp_a     = pa[DUT_LAT-1];
      assign cmp_b     = pb[DUT_LAT-1];
      assign cmp_exp   = pe[DUT_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    enter_done = 1'b0;
    unique case (state_q)
      IDLE: if (vec.start) state_d = RUN;
      RUN: begin
        if (vec.start) begin
          state_d = RUN;
        end else if (vec.end_test) begin
          state_d = DRAIN;
          drain_d = DRAIN_LEN;
        end
      end
      DRAIN: begin
        if (vec.start) begin
          state_d = RUN;
        end else if (drain_q == 2'd1) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      DONE: if (vec.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign mism        = cmp_valid && (vec.c_obs != cmp_exp);
  assign check_nx    = (cmp_valid && (check_cnt != CNT_MAX)) ? check_cnt + cnt_t'(1) : check_cnt;
  assign mismatch_nx = (mism && (mismatch_cnt != CNT_MAX)) ? mismatch_cnt + cnt_t'(1) : mismatch_cnt;
  assign cov_nx      = cmp_valid ? (coverage | (4'b0001 << {cmp_a, cmp_b})) : coverage;

  // pass is taken from the *_nx values so a compare on the final DRAIN edge counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_cnt     <= '0;
      mismatch_cnt  <= '0;
      coverage      <= 4'h0;
      err_pulse     <= 1'b0;
      err_sticky    <= 1'b0;
      first_err_vec <= 2'b00;
      pass          <= 1'b0;
    end else if (vec.start) begin
      check_cnt     <= '0;
      mismatch_cnt  <= '0;
      coverage      <= 4'h0;
      err_pulse     <= 1'b0;
      err_sticky    <= 1'b0;
      first_err_vec <= 2'b00;
      pass          <= 1'b0;
    end else begin
      check_cnt    <= check_nx;
      mismatch_cnt <= mismatch_nx;
      coverage     <= cov_nx;
      err_pulse    <= mism;
      if (mism) begin
        err_sticky <= 1'b1;
        if (!err_sticky) first_err_vec <= {cmp_a, cmp_b};
      end
      if (enter_done) pass <= (mismatch_nx == '0) && (cov_nx == 4'hF);
    end
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Self-checking response monitor for 2-input logic-gate DUTs; it is the receive/check end of the gate stimulus benches.
- Samples each applied input vector (a, b) and the DUT's observed output c_obs, then compares c_obs against the expected gate function after a programmable DUT latency.
- Counts checks and mismatches, tracks truth-table coverage and captures the first failing vector.
- Reports pass/fail when the test ends.

Parameters:
- GATE_OP, 3'd3, expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6-7 reserved, treated as NOR.
- DUT_LAT, 0, cycles from an (a, b) sample to its c_obs (0..3).
- CNT_W, 8, width of check/mismatch counters.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: clear all results, enter RUN
- end_test  in  1  pulse: stop accepting vectors, drain pipeline, report
- in_valid  in  1  a/b hold a new applied vector this cycle
- a  in  1  DUT input a
- b  in  1  DUT input b
- c_obs  in  1  DUT output, valid DUT_LAT cycles after its vector
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- pass  out  1  valid in DONE: no mismatches and full coverage
- err_pulse  out  1  one-cycle pulse per mismatch
- err_sticky  out  1  set on first mismatch, cleared only by start/reset
- mismatch_cnt  out  CNT_W  mismatches since start, saturating
- check_cnt  out  CNT_W  compares performed since start, saturating
- coverage  out  4  bit {a,b} set when that input combination was checked
- first_err_vec  out  2  {a,b} of the first mismatch; 0 if none

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All outputs and pipeline stages go to 0, including pass=0 and done=0.
- FSM states:
  - IDLE:
    - start -> RUN.
    - in_valid and end_test are ignored.
  - RUN:
    - in_valid loads {a, b, exp} into the pipeline.
    - end_test -> DRAIN.
    - start clears all results and the pipeline, and stays in RUN.
    - If start and end_test are asserted together, start wins.
  - DRAIN:
    - New in_valid is ignored; in-flight entries are still compared.
    - Lasts exactly DUT_LAT cycles, then -> DONE.
    - With DUT_LAT=0, DRAIN lasts 1 cycle and does no compares.
    - start -> RUN with a clear.
  - DONE:
    - Outputs are held.
    - start -> RUN with a clear.
- Expected value: exp = f_GATE_OP(a, b), computed at sample time.
- Pipeline:
  - DUT_LAT registered stages carrying {valid, a, b, exp}.
  - A compare occurs in the cycle the last stage is valid; with DUT_LAT=0, the compare is in the same cycle as in_valid (RUN only).
  - The compare uses c_obs from that same cycle.
- Compare results, all registered and visible the cycle after the compare:
  - check_cnt increments and sets coverage[{a,b}].
  - On c_obs != exp:
    - err_pulse=1 and mismatch_cnt increments.
    - err_sticky is set.
    - If err_sticky was 0, first_err_vec <= {a,b}.
- Counters saturate at 2^CNT_W-1 and never wrap.
- start clear:
  - All counters, coverage, err_sticky, first_err_vec and pipeline valids go to 0 on the edge start is sampled.
  - Compares due in that same cycle are discarded.
- pass:
  - Registered when entering DONE: pass = (mismatch_cnt==0) && (coverage==4'hF), using counts that include the final compare.
  - pass is 0 outside DONE.
- Reset mid-test: immediate return to IDLE with everything cleared; no partial report.

Test Plan:
- NOR, DUT_LAT=0:
  - Stimulus: start; apply 00,01,10,11,00 with correct c_obs (1,0,0,0,1); end_test.
  - Response: DONE after 1 DRAIN cycle; check_cnt=5, mismatch_cnt=0, coverage=4'hF, pass=1, err_sticky=0.
- NOR, DUT_LAT=0, fault:
  - Stimulus: c_obs forced to 1 for vectors 01 and 11; end_test.
  - Response: err_pulse twice; mismatch_cnt=2; first_err_vec=2'b01; pass=0.
- NOR, DUT_LAT=2:
  - Stimulus: c_obs delayed 2 cycles, back-to-back vectors, end_test right after the last vector.
  - Response: DRAIN lasts 2 cycles; last two vectors still checked; check_cnt=4; pass=1.
  - Variant with c_obs delayed 1 cycle instead: mismatch_cnt>0.
- Partial coverage:
  - Stimulus: only 00 and 11 applied, all correct, then end_test.
  - Response: coverage=4'b1001, mismatch_cnt=0, pass=0.
- Control:
  - Stimulus: start pulsed in RUN after 3 vectors with 1 error.
  - Response: all results cleared to 0, err_sticky=0, first_err_vec=0.
  - Stimulus: rst_n low mid-RUN.
  - Response: outputs 0 asynchronously, state IDLE; in_valid in IDLE has no effect on check_cnt.
- Saturation, CNT_W=3:
  - Stimulus: 10 faulty vectors.
  - Response: mismatch_cnt=7, check_cnt=7, no wrap.
